// File: rtl/wtile_load_sched_if.sv
// Handshake bundle between the W-tile load scheduler, its config/CPU side and
// the column loader. slave is the scheduler's view, master the environment's.
interface wtile_load_sched_if #(
   parameter int K_W = 10
);
   logic           cfg_start;
   logic [K_W-1:0] cfg_k_base;
   logic [K_W:0]   cfg_k_len;
   logic           abort;
   logic           ld_start_k;
   logic [K_W-1:0] ld_k_idx;
   logic           ld_col_valid;
   logic           ld_col_accept;
   logic           cpu_req;
   logic           cpu_gnt;
   logic           busy;
   logic           done;
   logic           err_range;
   logic           err_tmo;
   logic [K_W:0]   cols_done;

   modport master (
      output cfg_start, cfg_k_base, cfg_k_len, abort, ld_col_valid, cpu_req,
      input  ld_start_k, ld_k_idx, ld_col_accept, cpu_gnt, busy, done,
             err_range, err_tmo, cols_done
   );

   modport slave (
      input  cfg_start, cfg_k_base, cfg_k_len, abort, ld_col_valid, cpu_req,
      output ld_start_k, ld_k_idx, ld_col_accept, cpu_gnt, busy, done,
             err_range, err_tmo, cols_done
   );
endinterface

// File: rtl/wtile_load_sched.sv
// Sweeps W-tile columns k = base .. base+len-1 through the column loader and
// shares the SRAM write port with the CPU, which only wins between columns.
module wtile_load_sched #(
   parameter int KMAX    = 1024,
   parameter int K_W     = (KMAX <= 1) ? 1 : $clog2(KMAX),
   parameter int TMO_CYC = 4096
) (
   input logic               clk,
   input logic               rst,
   wtile_load_sched_if.slave bus
);
   localparam int             TMO_W   = $clog2(TMO_CYC + 1);
   // Counter starts at 0 on WAIT entry, so TMO_CYC-2 is the last idle count.
   localparam int             TMO_LIM = (TMO_CYC >= 2) ? TMO_CYC - 2 : 0;
   localparam logic [K_W+1:0] KMAX_V  = (K_W+2)'(KMAX);
   localparam logic [K_W:0]   ONE_C   = (K_W+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [K_W-1:0]   cur_k;
   logic [K_W:0]     len_q, cols_done;
   logic [TMO_W-1:0] tmo;
   logic             err_range, err_tmo;
   logic             start_ok, range_bad, acc, tmo_hit, last;
   logic [K_W+1:0]   k_end;

   assign k_end = {2'b00, bus.cfg_k_base} + {1'b0, bus.cfg_k_len};
   assign last  = (cols_done + ONE_C) == len_q;

   always_comb begin
      state_nxt         = state;
      bus.ld_start_k    = 1'b0;
      bus.ld_col_accept = 1'b0;
      bus.cpu_gnt       = 1'b0;
      bus.done          = 1'b0;
      start_ok          = 1'b0;
      range_bad         = 1'b0;
      acc               = 1'b0;
      tmo_hit           = 1'b0;
      case (state)
         IDLE: begin
            bus.cpu_gnt = bus.cpu_req;
            if (bus.cfg_start) begin
               if (k_end > KMAX_V) begin
                  range_bad = 1'b1;
               end else begin
                  start_ok  = 1'b1;
                  state_nxt = (bus.cfg_k_len == '0) ? DONE : ISSUE;
               end
            end
         end
         ISSUE: begin
            bus.cpu_gnt = bus.cpu_req;
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (!bus.cpu_req) begin
               bus.ld_start_k = 1'b1;
               state_nxt      = WAIT;
            end
         end
         WAIT: begin
            // abort beats a same-cycle column: the column is not acknowledged
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (bus.ld_col_valid) begin
               bus.ld_col_accept = 1'b1;
               acc               = 1'b1;
               state_nxt         = last ? DONE : ISSUE;
            end else if (tmo == TMO_W'(TMO_LIM)) begin
               tmo_hit   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.done  = !bus.abort;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cur_k     <= '0;
         len_q     <= '0;
         cols_done <= '0;
         tmo       <= '0;
         err_range <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_range <= range_bad;
         if (start_ok) begin
            cur_k     <= bus.cfg_k_base;
            len_q     <= bus.cfg_k_len;
            cols_done <= '0;
            err_tmo   <= 1'b0;
         end
         if (bus.ld_start_k)
            tmo <= '0;
         else if (state == WAIT && !bus.ld_col_valid)
            tmo <= tmo + TMO_W'(1);
         if (acc) begin
            cols_done <= cols_done + ONE_C;
            if (!last) cur_k <= cur_k + K_W'(1);
         end
         if (tmo_hit) err_tmo <= 1'b1;
      end
   end

   assign bus.ld_k_idx  = cur_k;
   assign bus.cols_done = cols_done;
   assign bus.err_range = err_range;
   assign bus.err_tmo   = err_tmo;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_wtile_load_sched.sv
// Bench for wtile_load_sched: each sweep is planned up front as a cycle timeline
// (CPU holds, loader latencies) and the DUT is checked against it cycle by cycle.
module tb_wtile_load_sched;
   localparam int KMAX = 1024;
   localparam int K_W  = 10;
   localparam int TMO  = 16;
   localparam int NC   = 512;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wtile_load_sched_if #(.K_W(K_W)) bus ();
   wtile_load_sched #(.KMAX(KMAX), .K_W(K_W), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int hold[64], lat[64], col_start[64];
   bit e_start[NC], e_acc[NC], e_done[NC], e_busy[NC], e_cpu[NC], e_val[NC], e_gnt[NC];
   int e_k[NC], e_cols[NC];
   int ncyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected timeline, cycle 0 = cfg_start. Column i: hold[i] CPU cycles,
   // one start cycle, then the loader answers lat[i] cycles after its start.
   task automatic build(input int base, input int len, input int abort_at);
      int c = 1;
      int cnt = 0;
      for (int i = 0; i < NC; i++) begin
         e_start[i] = 0; e_acc[i] = 0; e_done[i] = 0; e_busy[i] = 0;
         e_val[i] = 0; e_k[i] = 0; e_cols[i] = 0;
         e_cpu[i] = 1'($urandom_range(0, 1));
         e_gnt[i] = e_cpu[i];
      end
      for (int i = 0; i < len; i++) begin
         for (int h = 0; h < hold[i]; h++) begin
            e_cpu[c] = 1; e_gnt[c] = 1; e_busy[c] = 1; c++;
         end
         e_cpu[c] = 0; e_gnt[c] = 0; e_start[c] = 1; e_k[c] = base + i;
         e_busy[c] = 1; col_start[i] = c; c++;
         for (int w = 1; w < lat[i]; w++) begin
            e_gnt[c] = 0; e_busy[c] = 1; c++;
         end
         e_val[c] = 1; e_acc[c] = 1; e_gnt[c] = 0; e_busy[c] = 1; c++;
      end
      e_done[c] = 1; e_gnt[c] = 0; e_busy[c] = 1; c++;
      ncyc = c + 3;
      if (abort_at > 0) begin
         for (int i = abort_at + 1; i < NC; i++) begin
            e_start[i] = 0; e_acc[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_val[i] = 0; e_gnt[i] = e_cpu[i];
         end
      end
      for (int i = 1; i < NC; i++) begin
         e_cols[i] = cnt;
         if (e_acc[i]) cnt++;
      end
   endtask

   task automatic run(input int base, input int len, input int abort_at, input string tag);
      for (int c = 0; c < ncyc; c++) begin
         bus.cfg_start    = (c == 0) ? 1'b1 : (e_busy[c] ? 1'($urandom_range(0, 1)) : 1'b0);
         bus.cfg_k_base   = (c == 0) ? K_W'(base) : K_W'($urandom);
         bus.cfg_k_len    = (c == 0) ? (K_W+1)'(len) : (K_W+1)'($urandom);
         bus.cpu_req      = e_cpu[c];
         bus.ld_col_valid = e_val[c];
         bus.abort        = (c == abort_at);
         #1;
         chk($sformatf("%s.start@%0d", tag, c), bus.ld_start_k, e_start[c]);
         chk($sformatf("%s.accept@%0d", tag, c), bus.ld_col_accept, e_acc[c]);
         chk($sformatf("%s.gnt@%0d", tag, c), bus.cpu_gnt, e_gnt[c]);
         chk($sformatf("%s.done@%0d", tag, c), bus.done, e_done[c]);
         chk($sformatf("%s.busy@%0d", tag, c), bus.busy, e_busy[c]);
         if (c > 0) begin
            chk($sformatf("%s.cols@%0d", tag, c), bus.cols_done, e_cols[c]);
            chk($sformatf("%s.err_range@%0d", tag, c), bus.err_range, 0);
            chk($sformatf("%s.err_tmo@%0d", tag, c), bus.err_tmo, 0);
         end
         if (e_start[c]) chk($sformatf("%s.kidx@%0d", tag, c), bus.ld_k_idx, e_k[c]);
         tick();
      end
      bus.cfg_start = 1'b0; bus.abort = 1'b0; bus.ld_col_valid = 1'b0; bus.cpu_req = 1'b0;
   endtask

   task automatic rand_cols(input int len, input int hmax, input int lmax);
      for (int i = 0; i < 64; i++) begin
         hold[i] = (i < len) ? $urandom_range(0, hmax) : 0;
         lat[i]  = (i < len) ? $urandom_range(1, lmax) : 1;
      end
   endtask

   task automatic range_reject(input int base, input int len);
      bus.cfg_start = 1'b1; bus.cfg_k_base = K_W'(base); bus.cfg_k_len = (K_W+1)'(len);
      bus.cpu_req = 1'b0;
      tick();
      bus.cfg_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("range%0d+%0d.err_range@%0d", base, len, c), bus.err_range, (c == 1));
         chk($sformatf("range%0d+%0d.busy@%0d", base, len, c), bus.busy, 0);
         chk($sformatf("range%0d+%0d.start@%0d", base, len, c), bus.ld_start_k, 0);
         tick();
      end
   endtask

   task automatic tmo_test();
      int b = $urandom_range(0, 1000);
      for (int c = 0; c <= 20; c++) begin
         bus.cfg_start = (c == 0); bus.cfg_k_base = K_W'(b); bus.cfg_k_len = (K_W+1)'(3);
         bus.cpu_req = 1'b0; bus.ld_col_valid = 1'b0; bus.abort = 1'b0;
         #1;
         if (c >= 1) begin
            // err_tmo rises TMO cycles after the loader start pulse at c=1
            chk($sformatf("tmo.err_tmo@%0d", c), bus.err_tmo, (c >= 1 + TMO));
            chk($sformatf("tmo.done@%0d", c), bus.done, (c == 1 + TMO));
            chk($sformatf("tmo.busy@%0d", c), bus.busy, (c <= 1 + TMO));
            chk($sformatf("tmo.start@%0d", c), bus.ld_start_k, (c == 1));
            chk($sformatf("tmo.cols@%0d", c), bus.cols_done, 0);
            if (c == 1) chk("tmo.kidx", bus.ld_k_idx, b);
         end
         tick();
      end
      bus.cfg_start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".start"}, bus.ld_start_k, 0);
      chk({tag, ".accept"}, bus.ld_col_accept, 0);
      chk({tag, ".done"}, bus.done, 0);
      chk({tag, ".err_range"}, bus.err_range, 0);
      chk({tag, ".err_tmo"}, bus.err_tmo, 0);
      chk({tag, ".kidx"}, bus.ld_k_idx, 0);
      chk({tag, ".cols"}, bus.cols_done, 0);
      chk({tag, ".busy"}, bus.busy, 0);
   endtask

   initial begin
      int b, l, a;
      bus.cfg_start = 1'b0; bus.cfg_k_base = '0; bus.cfg_k_len = '0; bus.abort = 1'b0;
      bus.ld_col_valid = 1'b0; bus.cpu_req = 1'b0;
      repeat (3) tick();

      chk_reset_vals("reset");
      bus.cpu_req = 1'b1; #1;
      chk("reset.gnt_hi", bus.cpu_gnt, 1);
      bus.cpu_req = 1'b0; #1;
      chk("reset.gnt_lo", bus.cpu_gnt, 0);
      rst = 1'b1;
      tick();

      // base 4, three columns, loader answers 5 cycles after each start
      for (int i = 0; i < 64; i++) begin hold[i] = 0; lat[i] = 5; end
      build(4, 3, -1); run(4, 3, -1, "basic");

      range_reject(1000, 30);
      range_reject(1000, 25);

      // CPU holds the port for 3 cycles before column k=2 is issued
      rand_cols(3, 0, 6); hold[2] = 3;
      build(0, 3, -1); run(0, 3, -1, "cpuhold");

      // exact fit at the top of the tile, and the single last column
      rand_cols(24, 2, 6); build(1000, 24, -1); run(1000, 24, -1, "edge24");
      rand_cols(1, 2, 6);  build(1023, 1, -1);  run(1023, 1, -1, "edge1");

      tmo_test();
      rst = 1'b0; tick(); rst = 1'b1;
      chk("tmo_rst.err_tmo", bus.err_tmo, 0);
      tick();

      // abort while waiting on the third of five columns
      rand_cols(5, 2, 6); lat[2] = 4;
      build(20, 5, -1);
      a = col_start[2] + 2;
      build(20, 5, a); run(20, 5, a, "abort");
      rand_cols(2, 1, 4); build(100, 2, -1); run(100, 2, -1, "after_abort");

      for (int i = 0; i < 64; i++) begin hold[i] = 0; lat[i] = 1; end
      b = $urandom_range(0, KMAX - 1);
      build(b, 0, -1); run(b, 0, -1, "len0");

      // reset in the middle of a sweep
      for (int c = 0; c <= 5; c++) begin
         bus.cfg_start = (c == 0); bus.cfg_k_base = K_W'(7); bus.cfg_k_len = (K_W+1)'(4);
         bus.cpu_req = 1'b0; bus.ld_col_valid = (c == 2 || c == 4); bus.abort = 1'b0;
         if (c == 5) begin
            rst = 1'b0; bus.cpu_req = 1'b1;
         end
         #1;
         if (c == 5) begin
            chk("midrst.pre_kidx", bus.ld_k_idx, 9);
            chk("midrst.pre_cols", bus.cols_done, 2);
         end
         tick();
      end
      bus.cfg_start = 1'b0; bus.ld_col_valid = 1'b0;
      chk_reset_vals("midrst");
      chk("midrst.gnt", bus.cpu_gnt, 1);
      rst = 1'b1; bus.cpu_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("midrst.after_done@%0d", c), bus.done, 0);
         chk($sformatf("midrst.after_busy@%0d", c), bus.busy, 0);
      end

      for (int r = 0; r < 6; r++) begin
         l = $urandom_range(1, 8);
         b = $urandom_range(0, KMAX - l);
         rand_cols(l, 3, 8);
         build(b, l, -1); run(b, l, -1, $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
